// File: rtl/lstm_sequencer.sv
// Time-step sequencer closing the recurrent c/h loop around an lstm_cell.
// Optional LSTM_SEQ_INIT_EN: state reloads from init_c/init_h instead of zero.
module lstm_sequencer #(
    parameter int WIDTH    = 16,
    parameter int SEQ_LEN  = 8,
    parameter int CELL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seq_clear,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    output logic [WIDTH-1:0] cell_x,
    output logic [WIDTH-1:0] cell_c,
    output logic [WIDTH-1:0] cell_h,
    input  logic [WIDTH-1:0] cell_c_out,
    input  logic [WIDTH-1:0] cell_h_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_h,
    output logic [WIDTH-1:0] out_c,
`ifdef LSTM_SEQ_INIT_EN
    input  logic [WIDTH-1:0] init_c,
    input  logic [WIDTH-1:0] init_h,
`endif
    output logic             out_last
);

    localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int CNT_W  = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CELL_LAT - 1);

    typedef enum logic [1:0] {IDLE, APPLY, OUTPUT} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [STEP_W-1:0] step;
    logic              xfer, capture, handshake, clr_idle, load_clr;
    logic [WIDTH-1:0]  clr_c, clr_h;

    assign xfer      = (state == IDLE) && x_valid && x_ready && !seq_clear;
    assign capture   = (state == APPLY) && (cnt == CNT_LAST);
    assign handshake = (state == OUTPUT) && out_ready;
    assign clr_idle  = (state == IDLE) && seq_clear;

`ifdef LSTM_SEQ_INIT_EN
    // Async reset zeroes state; the first clean IDLE edge then pulls in init values.
    logic init_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_pend <= 1'b1;
        else        init_pend <= 1'b0;
    end

    assign clr_c    = init_c;
    assign clr_h    = init_h;
    assign load_clr = clr_idle || (handshake && out_last) ||
                      (init_pend && (state == IDLE) && !xfer);
`else
    assign clr_c    = '0;
    assign clr_h    = '0;
    assign load_clr = clr_idle || (handshake && out_last);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer)      state_nxt = APPLY;
            APPLY:   if (capture)   state_nxt = OUTPUT;
            OUTPUT:  if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_ready   <= 1'b0;
            cell_x    <= '0;
            cell_c    <= '0;
            cell_h    <= '0;
            out_valid <= 1'b0;
            out_h     <= '0;
            out_c     <= '0;
            out_last  <= 1'b0;
            cnt       <= '0;
            step      <= '0;
        end else begin
            // x_ready is registered, so it mirrors the state we are entering
            x_ready <= (state_nxt == IDLE);

            if (xfer) begin
                cell_x <= x_data;
                cnt    <= '0;
            end else if ((state == APPLY) && !capture) begin
                cnt <= cnt + 1'b1;
            end

            if (capture) begin
                cell_c    <= cell_c_out;
                cell_h    <= cell_h_out;
                out_c     <= cell_c_out;
                out_h     <= cell_h_out;
                out_last  <= (step == LAST_STEP);
                out_valid <= 1'b1;
            end else if (load_clr) begin
                cell_c <= clr_c;
                cell_h <= clr_h;
            end

            if (handshake) begin
                out_valid <= 1'b0;
                step      <= out_last ? '0 : step + 1'b1;
            end else if (clr_idle) begin
                step <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lstm_sequencer.sv
// Randomized + directed bench for lstm_sequencer; two instances (CELL_LAT 1 and 4)
// each closed around a stand-in cell and checked every cycle against a step-level model.
module tb_lstm_sequencer;

    localparam int W   = 16;
    localparam int SEQ = 3;
    localparam int LAT [2] = '{1, 4};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         t_xv  [2];
    logic         t_clr [2];
    logic         t_ord [2];
    logic [W-1:0] t_xd  [2];

    logic         d_xr [2], d_ov [2], d_ol [2];
    logic [W-1:0] d_cx [2], d_cc [2], d_ch [2], d_oh [2], d_oc [2];
    logic [W-1:0] d_cco [2], d_cho [2];

    int npass = 0;
    int ntot  = 0;

    // Stand-in cell: cheap functions of (x, c, h) so the loop's data flow is observable.
    function automatic logic [W-1:0] fc(input logic [W-1:0] x, input logic [W-1:0] c);
        return x + c + 16'd1;
    endfunction
    function automatic logic [W-1:0] fh(input logic [W-1:0] x, input logic [W-1:0] c,
                                        input logic [W-1:0] h);
        return x ^ {h[0], h[W-1:1]} ^ c;
    endfunction

    assign d_cco[0] = fc(d_cx[0], d_cc[0]);
    assign d_cho[0] = fh(d_cx[0], d_cc[0], d_ch[0]);
    assign d_cco[1] = fc(d_cx[1], d_cc[1]);
    assign d_cho[1] = fh(d_cx[1], d_cc[1], d_ch[1]);

    lstm_sequencer #(.WIDTH(W), .SEQ_LEN(SEQ), .CELL_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .seq_clear(t_clr[0]), .x_valid(t_xv[0]), .x_data(t_xd[0]),
        .x_ready(d_xr[0]), .cell_x(d_cx[0]), .cell_c(d_cc[0]), .cell_h(d_ch[0]),
        .cell_c_out(d_cco[0]), .cell_h_out(d_cho[0]), .out_valid(d_ov[0]),
        .out_ready(t_ord[0]), .out_h(d_oh[0]), .out_c(d_oc[0]),
`ifdef LSTM_SEQ_INIT_EN
        .init_c('0), .init_h('0),
`endif
        .out_last(d_ol[0]));

    lstm_sequencer #(.WIDTH(W), .SEQ_LEN(SEQ), .CELL_LAT(4)) u_lat (
        .clk(clk), .rst_n(rst_n), .seq_clear(t_clr[1]), .x_valid(t_xv[1]), .x_data(t_xd[1]),
        .x_ready(d_xr[1]), .cell_x(d_cx[1]), .cell_c(d_cc[1]), .cell_h(d_ch[1]),
        .cell_c_out(d_cco[1]), .cell_h_out(d_cho[1]), .out_valid(d_ov[1]),
        .out_ready(t_ord[1]), .out_h(d_oh[1]), .out_c(d_oc[1]),
`ifdef LSTM_SEQ_INIT_EN
        .init_c('0), .init_h('0),
`endif
        .out_last(d_ol[1]));

    // Model: phase 0 = waiting for a sample, 1 = cell settling, 2 = result offered.
    int           m_ph [2] = '{0, 0};
    int           m_cnt[2] = '{0, 0};
    int           m_stp[2] = '{0, 0};
    logic [W-1:0] m_x [2] = '{0, 0};
    logic [W-1:0] m_c [2] = '{0, 0};
    logic [W-1:0] m_h [2] = '{0, 0};
    logic [W-1:0] m_oc[2] = '{0, 0};
    logic [W-1:0] m_oh[2] = '{0, 0};
    logic         m_xr[2] = '{0, 0};
    logic         m_ov[2] = '{0, 0};
    logic         m_ol[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_ph[k] = 0; m_cnt[k] = 0; m_stp[k] = 0;
                m_x[k] = 0; m_c[k] = 0; m_h[k] = 0; m_oc[k] = 0; m_oh[k] = 0;
                m_xr[k] = 0; m_ov[k] = 0; m_ol[k] = 0;
            end else begin
                if (m_ph[k] == 0) begin
                    if (t_clr[k]) begin
                        m_c[k] = 0; m_h[k] = 0; m_stp[k] = 0;
                    end else if (m_xr[k] && t_xv[k]) begin
                        m_x[k] = t_xd[k]; m_cnt[k] = 0; m_ph[k] = 1;
                    end
                end else if (m_ph[k] == 1) begin
                    if (m_cnt[k] == LAT[k] - 1) begin
                        m_oc[k] = fc(m_x[k], m_c[k]);
                        m_oh[k] = fh(m_x[k], m_c[k], m_h[k]);
                        m_c[k]  = m_oc[k];
                        m_h[k]  = m_oh[k];
                        m_ol[k] = (m_stp[k] == SEQ - 1);
                        m_ov[k] = 1'b1;
                        m_ph[k] = 2;
                    end else begin
                        m_cnt[k]++;
                    end
                end else if (t_ord[k]) begin
                    m_ov[k] = 1'b0;
                    m_ph[k] = 0;
                    if (m_ol[k]) begin
                        m_stp[k] = 0; m_c[k] = 0; m_h[k] = 0;
                    end else begin
                        m_stp[k]++;
                    end
                end
                m_xr[k] = (m_ph[k] == 0);
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("x_ready",   k, W'(d_xr[k]), W'(m_xr[k]));
            chk("cell_x",    k, d_cx[k], m_x[k]);
            chk("cell_c",    k, d_cc[k], m_c[k]);
            chk("cell_h",    k, d_ch[k], m_h[k]);
            chk("out_valid", k, W'(d_ov[k]), W'(m_ov[k]));
            chk("out_c",     k, d_oc[k], m_oc[k]);
            chk("out_h",     k, d_oh[k], m_oh[k]);
            chk("out_last",  k, W'(d_ol[k]), W'(m_ol[k]));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t_xv[k] = 0; t_clr[k] = 0; t_ord[k] = 1; t_xd[k] = '0;
        end
        #2 chk("rst_x_ready", 0, W'(d_xr[0]), 16'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("x_ready_after_rst", 0, W'(d_xr[0]), 16'd1);

        // Step 1 from zero state
        t_xv[0] = 1; t_xd[0] = 16'hFFF0;
        tick();
        t_xv[0] = 0;
        chk("s1_cell_x", 0, d_cx[0], 16'hFFF0);
        chk("s1_cell_c", 0, d_cc[0], 16'h0000);
        chk("s1_cell_h", 0, d_ch[0], 16'h0000);
        tick();
        chk("s1_out_valid", 0, W'(d_ov[0]), 16'd1);
        chk("s1_out_c", 0, d_oc[0], 16'hFFF1);
        chk("s1_out_h", 0, d_oh[0], 16'hFFF0);
        tick();

        // Step 2 must see step 1's result as its state
        t_xv[0] = 1; t_xd[0] = 16'h0110;
        tick();
        t_xv[0] = 0;
        chk("s2_cell_c", 0, d_cc[0], 16'hFFF1);
        chk("s2_cell_h", 0, d_ch[0], 16'hFFF0);
        tick();
        chk("s2_out_c", 0, d_oc[0], 16'h0102);
        chk("s2_out_h", 0, d_oh[0], 16'h8119);

        // Back-pressure: result held, incoming samples ignored
        t_ord[0] = 0; t_xv[0] = 1; t_xd[0] = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out_valid", 0, W'(d_ov[0]), 16'd1);
            chk("hold_out_h", 0, d_oh[0], 16'h8119);
            chk("hold_x_ready", 0, W'(d_xr[0]), 16'd0);
        end
        t_xv[0] = 0; t_ord[0] = 1;
        tick();
        chk("rel_out_valid", 0, W'(d_ov[0]), 16'd0);
        chk("rel_x_ready", 0, W'(d_xr[0]), 16'd1);

        // Step 3 is the last of the sequence
        t_xv[0] = 1; t_xd[0] = 16'hFEF0;
        tick();
        t_xv[0] = 0;
        tick();
        chk("s3_out_last", 0, W'(d_ol[0]), 16'd1);
        tick();

        // Step 4 opens a fresh sequence
        t_xv[0] = 1; t_xd[0] = 16'h0005;
        tick();
        t_xv[0] = 0;
        chk("s4_cell_c", 0, d_cc[0], 16'h0000);
        chk("s4_cell_h", 0, d_ch[0], 16'h0000);
        tick();
        chk("s4_out_last", 0, W'(d_ol[0]), 16'd0);
        tick();

        // seq_clear beats a simultaneous sample
        t_clr[0] = 1; t_xv[0] = 1; t_xd[0] = 16'h0777;
        tick();
        chk("clr_x_ready", 0, W'(d_xr[0]), 16'd1);
        chk("clr_cell_c", 0, d_cc[0], 16'h0000);
        chk("clr_cell_x", 0, d_cx[0], 16'h0005);
        t_clr[0] = 0;
        tick();
        t_xv[0] = 0;
        chk("post_clr_x_ready", 0, W'(d_xr[0]), 16'd0);
        chk("post_clr_cell_x", 0, d_cx[0], 16'h0777);
        repeat (3) tick();

        // Async reset in the middle of a CELL_LAT=4 settle
        t_xv[1] = 1; t_xd[1] = 16'hABCD;
        tick();
        t_xv[1] = 0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cell_x", 1, d_cx[1], 16'h0000);
        chk("rst_x_ready", 1, W'(d_xr[1]), 16'd0);
        chk("rst_out_valid", 1, W'(d_ov[1]), 16'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_rel_x_ready", 1, W'(d_xr[1]), 16'd1);

        // Random traffic on both instances
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                t_xv[k]  = $urandom_range(0, 1) == 1;
                t_xd[k]  = W'($urandom);
                t_ord[k] = $urandom_range(0, 3) != 0;
                t_clr[k] = $urandom_range(0, 15) == 0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
